// File: rtl/mio_bus_responder.sv
// Memory/IO responder for the CPU memory port: word RAM, GPIO, switch and
// cycle-counter registers, paced by a programmable wait-state sequencer.
module mio_bus_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned AW          = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic [15:0] sw_in,
  output logic [31:0] data2CPU,
  output logic        MIO_ready,
  output logic [31:0] gpio_out,
  output logic        busy
);

  localparam int unsigned CW = 4;
  localparam logic [29:0] GPIO_WORD = 30'h3800_0000;
  localparam logic [29:0] SW_WORD   = 30'h3800_0001;
  localparam logic [29:0] CNT_WORD  = 30'h3800_0002;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] wcnt, wcnt_nx;
  logic [29:0]   lat_word;
  logic [31:0]   lat_data;
  logic          lat_wr;
  logic [31:0]   cycle_cnt;
  logic [31:0]   mem [DEPTH];

  logic          req, commit, latch_en;
  logic [29:0]   eff_word;
  logic [31:0]   eff_data, rd_sel;
  logic          eff_wr, ram_hit, gpio_hit, sw_hit, cnt_hit;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];
  assign req = mem_r | mem_w;

  // A zero-wait request commits from IDLE, before the operand latches are loaded
  assign eff_word = (state == S_IDLE) ? addr[31:2] : lat_word;
  assign eff_data = (state == S_IDLE) ? data_in    : lat_data;
  assign eff_wr   = (state == S_IDLE) ? mem_w      : lat_wr;

  assign ram_hit  = (eff_word[29:AW] == '0);
  assign gpio_hit = (eff_word == GPIO_WORD);
  assign sw_hit   = (eff_word == SW_WORD);
  assign cnt_hit  = (eff_word == CNT_WORD);

  assign MIO_ready = (state == S_ACK) || ((state == S_IDLE) && !req);
  assign busy      = (state != S_IDLE);

  // Read data selection
  always_comb begin
    rd_sel = '0;
    if (ram_hit)       rd_sel = mem[eff_word[AW-1:0]];
    else if (gpio_hit) rd_sel = gpio_out;
    else if (sw_hit)   rd_sel = {16'h0, sw_in};
    else if (cnt_hit)  rd_sel = cycle_cnt;
  end

  // Next-state logic; commit marks the edge that enters ACK
  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    commit   = 1'b0;
    latch_en = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          latch_en = 1'b1;
          if (WAIT_STATES == 0) begin
            state_nx = S_ACK;
            commit   = 1'b1;
          end else begin
            state_nx = S_WAIT;
            wcnt_nx  = CW'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        wcnt_nx = wcnt - CW'(1);
        if (wcnt <= CW'(1)) begin
          state_nx = S_ACK;
          commit   = 1'b1;
        end
      end
      S_ACK:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      wcnt      <= '0;
      lat_word  <= '0;
      lat_data  <= '0;
      lat_wr    <= 1'b0;
      data2CPU  <= '0;
      gpio_out  <= '0;
      cycle_cnt <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
      if (latch_en) begin
        lat_word <= addr[31:2];
        lat_data <= data_in;
        lat_wr   <= mem_w;
      end
      if (commit && !eff_wr) data2CPU <= rd_sel;
      if (commit && eff_wr && gpio_hit) gpio_out <= eff_data;
      // A counter load takes precedence over the increment
      if (commit && eff_wr && cnt_hit) cycle_cnt <= eff_data;
      else                             cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  // RAM array is not reset; a write cut short by reset never commits
  always_ff @(posedge clk) begin
    if (!reset && commit && eff_wr && ram_hit) mem[eff_word[AW-1:0]] <= eff_data;
  end

endmodule

// File: tb/tb_mio_bus_responder.sv
// Scoreboard bench for mio_bus_responder: one instance with two wait states,
// one with zero wait states for the back-to-back throughput scenario.
module tb_mio_bus_responder;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_r, mem_w;
  logic [31:0] addr, data_in;
  logic [15:0] sw_in;
  logic [31:0] data2CPU, gpio_out;
  logic        MIO_ready, busy;

  logic        mem_r0, mem_w0;
  logic [31:0] addr0, data_in0;
  logic [31:0] data2CPU0, gpio_out0;
  logic        MIO_ready0, busy0;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          edge_no  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_d  = 32'h0;
  logic [31:0] cnt_v   = 32'h0;
  int          cnt_e   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_no <= edge_no + 1;

  mio_bus_responder #(.DEPTH(1024), .AW(10), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .mem_r(mem_r), .mem_w(mem_w), .addr(addr),
    .data_in(data_in), .sw_in(sw_in), .data2CPU(data2CPU),
    .MIO_ready(MIO_ready), .gpio_out(gpio_out), .busy(busy)
  );

  mio_bus_responder #(.DEPTH(16), .AW(4), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .mem_r(mem_r0), .mem_w(mem_w0), .addr(addr0),
    .data_in(data_in0), .sw_in(16'h0), .data2CPU(data2CPU0),
    .MIO_ready(MIO_ready0), .gpio_out(gpio_out0), .busy(busy0)
  );

  // One full transaction on the WS=2 instance; expected data2CPU is queued at drive time
  task automatic do_txn(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd,
                        input logic use_cnt, input string nm, output int ce);
    int          lat;
    int          n0;
    logic [31:0] e;
    logic [31:0] got;
    @(negedge clk);
    mem_r = r; mem_w = w; addr = a; data_in = d;
    n0 = edge_no;
    if (w)            e = last_d;
    else if (use_cnt) e = cnt_v + 32'(n0 + WS - cnt_e);
    else              e = exp_rd;
    if (!w) last_d = e;
    exp_q.push_back(e);
    #1;
    n_checks++;
    if (MIO_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s ready_on_accept: MIO_ready=%b expected 0", nm, MIO_ready);
    end
    lat = 0;
    while (MIO_ready !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != WS + 1) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles expected %0d", nm, lat, WS + 1);
    end
    mem_r = 1'b0; mem_w = 1'b0;
    ce = n0 + 1 + WS;
    e = exp_q.pop_front();
    got = data2CPU;
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s data2CPU: got %h expected %h", nm, got, e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_r = 0; mem_w = 0; addr = 0; data_in = 0; sw_in = 0;
    mem_r0 = 0; mem_w0 = 0; addr0 = 0; data_in0 = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({data2CPU, gpio_out, busy, MIO_ready} !== {32'h0, 32'h0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: d=%h g=%h busy=%b rdy=%b expected 0 0 0 1",
               data2CPU, gpio_out, busy, MIO_ready);
    end
    n_checks++;
    if ({data2CPU0, busy0, MIO_ready0} !== {32'h0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state0: d=%h busy=%b rdy=%b expected 0 0 1",
               data2CPU0, busy0, MIO_ready0);
    end
  endtask

  task automatic test_ram();
    int ce;
    do_txn(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, "ram_wr", ce);
    do_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, "ram_rd", ce);
    do_txn(1'b0, 1'b1, 32'h0000_0FFC, 32'h1357_9BDF, 32'h0, 1'b0, "ram_top_wr", ce);
    do_txn(1'b1, 1'b0, 32'h0000_0FFC, 32'h0, 32'h1357_9BDF, 1'b0, "ram_top_rd", ce);
  endtask

  task automatic test_gpio_sw();
    int ce;
    do_txn(1'b0, 1'b1, 32'hE000_0000, 32'h0000_00A5, 32'h0, 1'b0, "gpio_wr", ce);
    n_checks++;
    if (gpio_out !== 32'h0000_00A5) begin
      n_fail++;
      $display("FAIL gpio_out: got %h expected 000000a5", gpio_out);
    end
    sw_in = 16'h1234;
    do_txn(1'b1, 1'b0, 32'hE000_0004, 32'h0, 32'h0000_1234, 1'b0, "sw_rd", ce);
    do_txn(1'b0, 1'b1, 32'hE000_0004, 32'hFFFF_FFFF, 32'h0, 1'b0, "sw_wr_ignored", ce);
    do_txn(1'b1, 1'b0, 32'hE000_0000, 32'h0, 32'h0000_00A5, 1'b0, "gpio_rd", ce);
  endtask

  task automatic test_unmapped_dual();
    int ce;
    do_txn(1'b1, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b0, "unmapped_rd", ce);
    do_txn(1'b1, 1'b0, 32'h0000_1000, 32'h0, 32'h0, 1'b0, "past_ram_rd", ce);
    do_txn(1'b1, 1'b1, 32'h0000_0004, 32'h0000_0055, 32'h0, 1'b0, "dual_strobe", ce);
    do_txn(1'b1, 1'b0, 32'h0000_0004, 32'h0, 32'h0000_0055, 1'b0, "dual_rd", ce);
  endtask

  task automatic test_counter();
    int ce;
    do_txn(1'b0, 1'b1, 32'hE000_0008, 32'hFFFF_FFFE, 32'h0, 1'b0, "cnt_wr", ce);
    cnt_v = 32'hFFFF_FFFE;
    cnt_e = ce;
    @(negedge clk);
    do_txn(1'b1, 1'b0, 32'hE000_0008, 32'h0, 32'h0, 1'b1, "cnt_wrap_rd", ce);
  endtask

  task automatic test_reset_mid();
    int ce;
    do_txn(1'b0, 1'b1, 32'h0000_0020, 32'h0000_0011, 32'h0, 1'b0, "pre_wr", ce);
    @(negedge clk);
    mem_w = 1'b1; addr = 32'h0000_0020; data_in = 32'h0000_0077;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy: busy=%b expected 1", busy);
    end
    reset = 1'b1; mem_w = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, MIO_ready, data2CPU, gpio_out} !== {1'b0, 1'b1, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL mid_reset: busy=%b rdy=%b d=%h g=%h expected 0 1 0 0",
               busy, MIO_ready, data2CPU, gpio_out);
    end
    reset = 1'b0;
    last_d = 32'h0;
    do_txn(1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h0000_0011, 1'b0, "dropped_wr", ce);
  endtask

  // Zero-wait instance: alternating write/read, one transaction every two cycles
  task automatic test_back_to_back();
    logic [31:0] e;
    logic [31:0] a;
    logic [31:0] d;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      a = 32'((i / 2) * 4);
      d = 32'hC0DE_0000 + 32'(i);
      if (i % 2 == 0) begin
        mem_w0 = 1'b1; mem_r0 = 1'b0;
      end else begin
        mem_w0 = 1'b0; mem_r0 = 1'b1;
        exp_q.push_back(32'hC0DE_0000 + 32'(i - 1));
      end
      addr0 = a; data_in0 = d;
      if (i == 0) #1;
      else @(negedge clk);
      n_checks++;
      if (MIO_ready0 !== 1'b0 || busy0 !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_accept[%0d]: rdy=%b busy=%b expected 0 0", i, MIO_ready0, busy0);
      end
      @(negedge clk);
      n_checks++;
      if (MIO_ready0 !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ack[%0d]: rdy=%b expected 1", i, MIO_ready0);
      end
      if (i % 2 == 1) begin
        e = exp_q.pop_front();
        n_checks++;
        if (data2CPU0 !== e) begin
          n_fail++;
          $display("FAIL b2b_rd[%0d]: got %h expected %h", i, data2CPU0, e);
        end
      end
    end
    mem_r0 = 1'b0; mem_w0 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_ram();
    test_gpio_sw();
    test_unmapped_dual();
    test_counter();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
